// File: rtl/clk_div_bank_if.sv
// Control/status bundle for clk_div_bank: per-channel enable, divisor load,
// shared sync, and the registered divider outputs.
interface clk_div_bank_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DIV_W  = 8
);
  logic [NUM_CH-1:0]       ch_en;
  logic                    sync;
  logic [NUM_CH*DIV_W-1:0] div_value;
  logic [NUM_CH-1:0]       div_load;
  logic [NUM_CH-1:0]       div_ack;
  logic [NUM_CH-1:0]       div_out;
  logic [NUM_CH-1:0]       div_tick;

  modport master (
    output ch_en, sync, div_value, div_load,
    input  div_ack, div_out, div_tick
  );

  modport slave (
    input  ch_en, sync, div_value, div_load,
    output div_ack, div_out, div_tick
  );
endinterface

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH synchronous programmable dividers with period-boundary
// divisor reload and a shared phase-alignment sync.
module clk_div_bank #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic           clk,
  input  logic           reset,
  clk_div_bank_if.slave  bus
);

  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
  localparam logic [DIV_W:0]   ONE_X = (DIV_W+1)'(1);

  logic [DIV_W-1:0]  r_n    [NUM_CH];
  logic [DIV_W-1:0]  r_p    [NUM_CH];
  logic [DIV_W-1:0]  r_pend [NUM_CH];
  logic [NUM_CH-1:0] r_pend_v;
  logic [NUM_CH-1:0] r_run;
  logic [NUM_CH-1:0] r_out;
  logic [NUM_CH-1:0] r_tick;
  logic [NUM_CH-1:0] r_ack;

  logic [DIV_W-1:0]  w_n      [NUM_CH];
  logic [DIV_W-1:0]  w_p      [NUM_CH];
  logic [DIV_W-1:0]  w_pend   [NUM_CH];
  logic [DIV_W-1:0]  w_ld_val [NUM_CH];
  logic [DIV_W-1:0]  w_eff    [NUM_CH];
  logic [DIV_W:0]    w_half   [NUM_CH];
  logic [NUM_CH-1:0] w_pend_v;
  logic [NUM_CH-1:0] w_eff_v;
  logic [NUM_CH-1:0] w_bnd;
  logic [NUM_CH-1:0] w_out;
  logic [NUM_CH-1:0] w_tick;
  logic [NUM_CH-1:0] w_ack;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_ld_val[i] = bus.div_value[i*DIV_W +: DIV_W];
      // A load in this cycle overrides (and bypasses) any older pending value.
      w_eff_v[i]  = bus.div_load[i] | r_pend_v[i];
      w_eff[i]    = bus.div_load[i] ? w_ld_val[i] : r_pend[i];
      w_half[i]   = ({1'b0, r_n[i]} + ONE_X) >> 1;
      // Halted channels and loads of 0 are treated as a boundary every cycle.
      w_bnd[i]    = ~r_run[i] | bus.sync | (r_n[i] == '0) |
                    (r_p[i] == r_n[i] - ONE) |
                    (bus.div_load[i] & (w_ld_val[i] == '0));

      w_n[i]      = r_n[i];
      w_p[i]      = r_p[i];
      w_pend[i]   = r_pend[i];
      w_pend_v[i] = r_pend_v[i];
      w_out[i]    = 1'b0;
      w_tick[i]   = 1'b0;
      w_ack[i]    = 1'b0;

      if (!bus.ch_en[i]) begin
        w_p[i]      = '0;
        w_pend[i]   = w_eff[i];
        w_pend_v[i] = w_eff_v[i];
      end else if (w_bnd[i]) begin
        w_p[i] = '0;
        if (w_eff_v[i]) begin
          w_n[i]      = w_eff[i];
          w_pend_v[i] = 1'b0;
          w_ack[i]    = 1'b1;
        end
        w_tick[i] = (w_n[i] != '0);
        w_out[i]  = (w_n[i] != '0);
      end else begin
        w_p[i]      = r_p[i] + ONE;
        w_pend[i]   = w_eff[i];
        w_pend_v[i] = w_eff_v[i];
        w_out[i]    = ({1'b0, w_p[i]} < w_half[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_n[i]    <= DIV_W'(DEFAULT_DIV);
        r_p[i]    <= '0;
        r_pend[i] <= '0;
      end
      r_pend_v <= '0;
      r_run    <= '0;
      r_out    <= '0;
      r_tick   <= '0;
      r_ack    <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_n[i]    <= w_n[i];
        r_p[i]    <= w_p[i];
        r_pend[i] <= w_pend[i];
      end
      r_pend_v <= w_pend_v;
      r_run    <= bus.ch_en;
      r_out    <= w_out;
      r_tick   <= w_tick;
      r_ack    <= w_ack;
    end
  end

  assign bus.div_out  = r_out;
  assign bus.div_tick = r_tick;
  assign bus.div_ack  = r_ack;

endmodule
